pipeline_load_unit: RTL and testbench

//  Read-side counterpart of the ALU->register->memory pipeline: moves data memory -> register bank.
//  3-stage load pipeline.

---
 rtl/pipeline_load_unit_if.sv | 15 +
 rtl/pipeline_load_unit.sv | 104 ++++++++++
 tb/tb_pipeline_load_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_load_unit_if.sv
// rtl/pipeline_load_unit_if.sv - instruction issue handshake bundle for the load pipeline
interface pipeline_load_unit_if #(
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rd;
  logic [3:0]        func;
  logic [ADDR_W-1:0] addr;

  modport master (output in_valid, rs1, rd, func, addr, input in_ready);
  modport slave  (input in_valid, rs1, rd, func, addr, output in_ready);
endinterface

// File: rtl/pipeline_load_unit.sv
// rtl/pipeline_load_unit.sv - 3-stage load pipeline: memory[addr] (op) register[rs1] -> register[rd]
module pipeline_load_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8,
  parameter int REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  pipeline_load_unit_if.slave ins,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic [REG_AW-1:0] rf_raddr,
  output logic [DATA_W-1:0] rf_rdata,
  output logic [DATA_W-1:0] z_out,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic              bad_func
);
  localparam int HALF = DATA_W / 2;
  localparam logic [DATA_W-1:0] LO_MASK = {DATA_W{1'b1}} >> (DATA_W - HALF);

  logic [DATA_W-1:0] mem  [2**ADDR_W];
  logic [DATA_W-1:0] regs [2**REG_AW];

  logic              s1_valid, s2_valid;
  logic [REG_AW-1:0] s1_rd, s2_rd;
  logic [3:0]        s1_func, s2_func;
  logic [ADDR_W-1:0] s1_addr;
  logic [DATA_W-1:0] s1_a, s2_a, s2_m;
  logic [DATA_W-1:0] z;
  logic              accept, s2_defined, uses_rs1;

  // Only LDADD/LDSUB read rs1; undefined producers never write, so they cannot cause a hazard.
  assign uses_rs1     = (ins.func == 4'd3) || (ins.func == 4'd4);
  assign ins.in_ready = !(uses_rs1 &&
                          ((s1_valid && !s1_func[3] && s1_rd == ins.rs1) ||
                           (s2_valid && !s2_func[3] && s2_rd == ins.rs1)));
  assign accept     = ins.in_valid && ins.in_ready;
  assign s2_defined = !s2_func[3];
  assign rf_rdata   = regs[rf_raddr];

  always_comb begin
    z = s2_m;
    case (s2_func)
      4'd0:    z = s2_m;
      4'd1:    z = s2_m >> HALF;
      4'd2:    z = s2_m & LO_MASK;
      4'd3:    z = s2_m + s2_a;
      4'd4:    z = s2_m - s2_a;
      4'd5:    z = {DATA_W{1'b0}} - s2_m;
      4'd6:    z = s2_m >> 1;
      4'd7:    z = s2_m << 1;
      default: z = s2_m;
    endcase
  end

  // Preload port; nonblocking semantics give a same-edge S2 read the old word.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_rd    <= '0;
      s1_func  <= '0;
      s1_addr  <= '0;
      s1_a     <= '0;
      s2_valid <= 1'b0;
      s2_rd    <= '0;
      s2_func  <= '0;
      s2_a     <= '0;
      s2_m     <= '0;
      z_out    <= '0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      bad_func <= 1'b0;
      for (int i = 0; i < 2**REG_AW; i++) regs[i] <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_rd   <= ins.rd;
        s1_func <= ins.func;
        s1_addr <= ins.addr;
        s1_a    <= regs[ins.rs1];
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_rd   <= s1_rd;
        s2_func <= s1_func;
        s2_a    <= s1_a;
        s2_m    <= mem[s1_addr];
      end
      wb_valid <= s2_valid && s2_defined;
      bad_func <= s2_valid && !s2_defined;
      if (s2_valid && s2_defined) begin
        regs[s2_rd] <= z;
        z_out       <= z;
        wb_rd       <= s2_rd;
      end
    end
  end
endmodule

// File: tb/tb_pipeline_load_unit.sv
// tb/tb_pipeline_load_unit.sv - directed self-checking bench for pipeline_load_unit
module tb_pipeline_load_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_we = 1'b0;
  logic [7:0]  mem_waddr = '0;
  logic [15:0] mem_wdata = '0;
  logic [3:0]  rf_raddr = '0;
  logic [15:0] rf_rdata, z_out;
  logic        wb_valid, bad_func;
  logic [3:0]  wb_rd;

  pipeline_load_unit_if #(.ADDR_W(8), .REG_AW(4)) bus ();

  pipeline_load_unit #(.DATA_W(16), .ADDR_W(8), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .ins(bus),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .z_out(z_out), .wb_valid(wb_valid), .wb_rd(wb_rd), .bad_func(bad_func)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] z_q [$];
  logic [3:0]  rd_q [$];
  int          cyc_q [$];
  int          bad_cnt = 0;
  int          bad_cyc = 0;
  logic [15:0] bad_z = '0;

  always @(negedge clk) begin
    if (wb_valid) begin
      z_q.push_back(z_out);
      rd_q.push_back(wb_rd);
      cyc_q.push_back(cyc);
    end
    if (bad_func) begin
      bad_cnt++;
      bad_cyc = cyc;
      bad_z   = z_out;
    end
  end

  int total = 0;
  int bad = 0;
  int stall_n, acc_cyc, a1, a2, a3, n_wb;
  logic [15:0] v;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (4) step();
  endtask

  task automatic clear_log();
    z_q.delete();
    rd_q.delete();
    cyc_q.delete();
    bad_cnt = 0;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] d);
    mem_we = 1'b1; mem_waddr = a; mem_wdata = d;
    step();
    mem_we = 1'b0;
  endtask

  task automatic rreg(input logic [3:0] i, output logic [15:0] val);
    rf_raddr = i;
    #1;
    val = rf_rdata;
  endtask

  task automatic issue(input logic [3:0] d, input logic [3:0] s, input logic [3:0] f,
                       input logic [7:0] a);
    int n;
    n = 0;
    bus.rd = d; bus.rs1 = s; bus.func = f; bus.addr = a; bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) check("issue_stall_bound", {31'd0, bus.in_ready}, 32'd1);
    stall_n = n;
    step();
    acc_cyc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic check_wb(input int idx, input logic [15:0] ez, input logic [3:0] erd, input int ecyc);
    if (z_q.size() <= idx) begin
      check("wb_count", z_q.size(), idx + 1);
    end else begin
      check("wb_z", z_q[idx], ez);
      check("wb_rd", rd_q[idx], erd);
      check("wb_cycle", cyc_q[idx], ecyc);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.rd = '0; bus.rs1 = '0; bus.func = '0; bus.addr = '0;
    step(); step();
    rst = 1'b0;
    #1;
    check("rst_z_out", z_out, 16'h0);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_bad_func", bad_func, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);

    // 1: reset with two instructions in flight
    preload(8'd3, 16'd7);
    preload(8'd4, 16'd8);
    issue(4'd1, 4'd0, 4'd0, 8'd3);
    drain();
    rreg(4'd1, v); check("pre_rst_r1", v, 16'd7);
    clear_log();
    issue(4'd6, 4'd0, 4'd0, 8'd3);
    issue(4'd7, 4'd0, 4'd0, 8'd4);
    rst = 1'b1;
    #1;
    check("rst_mid_z_out", z_out, 16'h0);
    step();
    rst = 1'b0;
    drain();
    check("rst_no_wb", z_q.size(), 0);
    check("rst_z_after", z_out, 16'h0);
    for (int i = 0; i < 16; i++) begin
      rreg(i[3:0], v);
      check($sformatf("rst_reg%0d", i), v, 16'h0);
    end

    // 2: streaming
    preload(8'd125, 16'h1234);
    preload(8'd126, 16'h00FF);
    preload(8'd127, 16'h8001);
    preload(8'd128, 16'h0002);
    clear_log();
    issue(4'd10, 4'd0, 4'd0, 8'd125);
    a1 = acc_cyc;
    issue(4'd12, 4'd0, 4'd1, 8'd125);
    issue(4'd14, 4'd0, 4'd2, 8'd125);
    issue(4'd13, 4'd0, 4'd7, 8'd128);
    drain();
    check_wb(0, 16'h1234, 4'd10, a1 + 2);
    check_wb(1, 16'h0012, 4'd12, a1 + 3);
    check_wb(2, 16'h0034, 4'd14, a1 + 4);
    check_wb(3, 16'h0004, 4'd13, a1 + 5);
    rreg(4'd12, v); check("stream_r12", v, 16'h0012);

    // 3: read-after-write hazard
    preload(8'd10, 16'd5);
    issue(4'd2, 4'd0, 4'd0, 8'd10);
    issue(4'd3, 4'd2, 4'd3, 8'd10);
    check("hazard_stall_cycles", stall_n, 2);
    drain();
    rreg(4'd3, v); check("hazard_r3", v, 16'd10);

    // 4: wrap-around arithmetic
    preload(8'd20, 16'd1);
    preload(8'd0, 16'd0);
    issue(4'd1, 4'd0, 4'd0, 8'd20);
    issue(4'd4, 4'd1, 4'd4, 8'd126);
    issue(4'd5, 4'd1, 4'd4, 8'd0);
    issue(4'd6, 4'd0, 4'd5, 8'd127);
    issue(4'd7, 4'd0, 4'd6, 8'd127);
    drain();
    rreg(4'd4, v); check("ldsub_r4", v, 16'h00FE);
    rreg(4'd5, v); check("ldsub_wrap_r5", v, 16'hFFFF);
    rreg(4'd6, v); check("ldneg_r6", v, 16'h7FFF);
    rreg(4'd7, v); check("ldshr_r7", v, 16'h4000);

    // 5: undefined func between two loads
    clear_log();
    issue(4'd8, 4'd0, 4'd0, 8'd125);
    a1 = acc_cyc;
    issue(4'd5, 4'd0, 4'd9, 8'd126);
    a2 = acc_cyc;
    issue(4'd9, 4'd0, 4'd0, 8'd128);
    a3 = acc_cyc;
    drain();
    check("bad_wb_count", z_q.size(), 2);
    check_wb(0, 16'h1234, 4'd8, a1 + 2);
    check_wb(1, 16'h0002, 4'd9, a3 + 2);
    check("bad_pulses", bad_cnt, 1);
    check("bad_cycle", bad_cyc, a2 + 2);
    check("bad_z_hold", bad_z, 16'h1234);
    rreg(4'd5, v); check("bad_r5_kept", v, 16'hFFFF);

    // 6: preload write colliding with S2 read
    preload(8'd50, 16'h1111);
    issue(4'd11, 4'd0, 4'd0, 8'd50);
    mem_we = 1'b1; mem_waddr = 8'd50; mem_wdata = 16'hAAAA;
    step();
    mem_we = 1'b0;
    drain();
    rreg(4'd11, v); check("collide_old", v, 16'h1111);
    issue(4'd12, 4'd0, 4'd0, 8'd50);
    drain();
    rreg(4'd12, v); check("collide_new", v, 16'hAAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
